life_datapath: RTL and testbench



---
 rtl/life_datapath.sv | 52 +++++
 tb/tb_life_datapath.sv | 129 ++++++++++++
 2 files changed

// File: rtl/life_datapath.sv
// Next-generation engine for an 8x8 Game of Life board with dead (non-wrapping) edges.
// The next generation is combinational from seed and registered into grid each clock.
module life_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] seed,
    output logic [63:0] grid
);

    // Board framed by a one-cell ring of permanently dead cells, so every
    // cell sees exactly eight neighbour positions and edges need no special case.
    logic [9:0]  padded [10];
    logic [3:0]  count  [64];
    logic [63:0] next_grid;

    // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latches are inferred.
    always_comb begin
        for (int r = 0; r < 10; r++) begin
            padded[r] = '0;
        end
        for (int r = 0; r < 8; r++) begin
            padded[r + 1][8:1] = seed[8 * r +: 8];
        end

        next_grid = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                count[8 * r + c] = '0;
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        if (!(dr == 1 && dc == 1)) begin
                            count[8 * r + c] = count[8 * r + c] + {3'b000, padded[r + dr][c + dc]};
                        end
                    end
                end
                // Survival on 2 or 3, birth on exactly 3.
                next_grid[8 * r + c] = (count[8 * r + c] == 4'd3) ||
                                       (seed[8 * r + c] && count[8 * r + c] == 4'd2);
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            grid <= '0;
        end else begin
            grid <= next_grid;
        end
    end

endmodule

// File: tb/tb_life_datapath.sv
// Self-checking bench for life_datapath: directed vector table plus feedback and
// mid-run reset sequences checked against a shift-based software Life model.
module tb_life_datapath;

    logic        clk;
    logic        reset;
    logic [63:0] seed;
    logic [63:0] grid;

    int checks = 0;
    int errors = 0;

    life_datapath dut (
        .clk   (clk),
        .reset (reset),
        .seed  (seed),
        .grid  (grid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [63:0] seed;
        logic [63:0] expected;
    } vector_t;

    localparam logic [63:0] COL0 = 64'h0101_0101_0101_0101;
    localparam logic [63:0] COL7 = 64'h8080_8080_8080_8080;

    // Independent model: eight shifted copies of the board, one per neighbour
    // direction, with wrapped columns masked off; counted bit by bit.
    function automatic logic [63:0] life_model(input logic [63:0] b);
        logic [63:0] n [8];
        logic [63:0] result;
        int          sum;
        n[0] = (b >> 1) & ~COL7;
        n[1] = (b << 1) & ~COL0;
        n[2] = b >> 8;
        n[3] = b << 8;
        n[4] = (b >> 9) & ~COL7;
        n[5] = (b >> 7) & ~COL0;
        n[6] = (b << 7) & ~COL7;
        n[7] = (b << 9) & ~COL0;
        result = '0;
        for (int i = 0; i < 64; i++) begin
            sum = 0;
            for (int k = 0; k < 8; k++) begin
                sum += int'(n[k][i]);
            end
            result[i] = (sum == 3) || (b[i] && sum == 2);
        end
        return result;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic step(input logic rst, input logic [63:0] s);
        reset = rst;
        seed  = s;
        @(posedge clk);
        #1;
    endtask

    vector_t vectors [15];
    logic [63:0] model_state;

    initial begin
        vectors[0]  = '{"reset_ones_0",  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vectors[1]  = '{"reset_ones_1",  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vectors[2]  = '{"ones_corners",  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8100_0000_0000_0081};
        vectors[3]  = '{"blinker_v",     1'b0, 64'h0000_0000_0404_0400, 64'h0000_0000_000E_0000};
        vectors[4]  = '{"blinker_h",     1'b0, 64'h0000_0000_000E_0000, 64'h0000_0000_0404_0400};
        vectors[5]  = '{"block",         1'b0, 64'h0000_0000_0000_0303, 64'h0000_0000_0000_0303};
        vectors[6]  = '{"l_tromino",     1'b0, 64'h0000_0000_0000_0103, 64'h0000_0000_0000_0303};
        vectors[7]  = '{"lone_corner",   1'b0, 64'h8000_0000_0000_0000, 64'h0};
        vectors[8]  = '{"pair_col7",     1'b0, 64'h0000_0000_0000_8080, 64'h0};
        vectors[9]  = '{"pair_col0",     1'b0, 64'h0000_0000_0000_0101, 64'h0};
        vectors[10] = '{"empty",         1'b0, 64'h0,                   64'h0};
        vectors[11] = '{"row0_full",     1'b0, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_7E7E};
        vectors[12] = '{"row7_full",     1'b0, 64'hFF00_0000_0000_0000, 64'h7E7E_0000_0000_0000};
        vectors[13] = '{"col7_full",     1'b0, 64'h8080_8080_8080_8080, 64'h00C0_C0C0_C0C0_C000};
        vectors[14] = '{"reset_mid",     1'b1, 64'h0000_0000_0000_0303, 64'h0};

        reset = 1'b1;
        seed  = '0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            step(vectors[i].rst, vectors[i].seed);
            check(vectors[i].name, grid, vectors[i].expected);
        end

        // Feedback run: grid is fed straight back into seed.
        model_state = 64'h0412_6424_0034_3C28;
        step(1'b0, model_state);
        model_state = life_model(model_state);
        check("feedback_gen1", grid, model_state);
        for (int g = 2; g <= 5; g++) begin
            step(1'b0, grid);
            model_state = life_model(model_state);
            check($sformatf("feedback_gen%0d", g), grid, model_state);
        end

        // Mid-run reset during blinker oscillation.
        step(1'b0, 64'h0000_0000_0404_0400);
        check("osc_phase_h", grid, 64'h0000_0000_000E_0000);
        step(1'b0, grid);
        check("osc_phase_v", grid, 64'h0000_0000_0404_0400);
        step(1'b1, grid);
        check("osc_reset", grid, 64'h0);
        step(1'b0, seed);
        check("osc_after_reset", grid, 64'h0000_0000_000E_0000);
        step(1'b0, grid);
        check("osc_resume", grid, life_model(64'h0000_0000_000E_0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
